crc_frame_checker: RTL and testbench
====================================

# crc_frame_checker

Frame-level CRC verifier that acts as the initiator on a CRC generator's interface. Accepts a frame of data words followed by one received CRC word on a valid/ready stream, and feeds each data word into the CRC generator. Compares the generator's final result with the received CRC and reports pass/fail. Sits between a peripheral's receive buffer and the polymorphic CRC generator inside the APB CRC subsystem.

## Interface
- WORD_SIZE, 32, data/CRC word width (matches the CRC generator)
- LEN_W, 8, width of frame length field (frames of 1..2^LEN_W-1 words)
- TIMEOUT_CYCLES, 64, wait limit on gen_ready (used only when the timeout feature is compiled in)

- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- frame_len  in  LEN_W  number of data words; latched on start
- orient  in  WORD_SIZE  CRC orientation/config word; latched on start
- s_data  in  WORD_SIZE  stream word (data words, then CRC word)
- s_valid  in  1  s_data valid
- s_ready  out  1  checker accepts s_data this cycle
- gen_data_in  out  WORD_SIZE  word to generator
- gen_start  out  1  one-cycle strobe: generator consumes gen_data_in
- gen_reset  out  1  one-cycle strobe: clear generator accumulator
- gen_orient  out  WORD_SIZE  latched orient, held stable for the whole frame
- gen_data_out  in  WORD_SIZE  generator running CRC, valid while gen_ready=1
- gen_ready  in  1  generator idle, result current
- busy  out  1  frame in progress (state != IDLE)
- done  out  1  one-cycle completion pulse
- pass  out  1  crc_calc == crc_rx; valid from done, held until next start
- len_err  out  1  frame_len was 0
- timeout  out  1  generator wait exceeded limit
- crc_calc  out  WORD_SIZE  captured generator result
- crc_rx  out  WORD_SIZE  captured received CRC word

## Operation
- States: IDLE, CLEAR, FEED, WAIT, CRCWORD, DONE.
- IDLE: on start=1:
  - Latch frame_len into a remaining counter and orient into gen_orient.
  - Clear pass, len_err, timeout, crc_calc, crc_rx.
  - frame_len==0 -> DONE with len_err=1, pass=0. Otherwise -> CLEAR.
- CLEAR: gen_reset=1 for exactly one cycle -> FEED.
- FEED:
  - s_ready = gen_ready; gen_data_in = s_data (combinational); gen_start = s_valid & gen_ready.
  - On transfer: decrement remaining -> WAIT.
- WAIT:
  - Minimum one cycle. The handshake rule is that the next gen_start is never issued in the cycle after a gen_start.
  - Leave when gen_ready=1 and capture gen_data_out into crc_calc. remaining==0 -> CRCWORD, else -> FEED.
- CRCWORD: s_ready=1; on s_valid capture s_data into crc_rx -> DONE.
- DONE: done=1 for one cycle; pass = (crc_calc==crc_rx) unless len_err or timeout -> IDLE.
- start while busy: ignored. s_valid outside FEED/CRCWORD: not accepted (s_ready=0).
- Remaining counter never underflows; decrement only occurs in FEED.

## Timing
- Reset values: all outputs 0; state IDLE; gen_orient 0; counters 0.
- nRST asserted mid-frame: immediate return to IDLE with all outputs 0. No done pulse. A partially fed generator is cleared by the gen_reset of the next frame.
- Best-case latency, with s_valid always high and gen_ready high in each WAIT:
  - Cycle 0: start sampled.
  - Cycle 1: CLEAR.
  - Cycles 2..2N+1: FEED/WAIT pairs.
  - Cycle 2N+2: CRC word accepted.
  - Cycle 2N+3: done=1.
- frame_len==0: done=1 at cycle 1.
- Throughput: one data word per 2 cycles maximum.
- gen_start and s_ready are high in the same cycle as the transfer; they are never high in WAIT, CLEAR, or DONE.
- pass, crc_calc, crc_rx, len_err, and timeout hold from DONE until the next accepted start.

## Configuration
- CRC_CHECK_TIMEOUT_EN defined:
  - A WAIT-state counter counts cycles with gen_ready=0.
  - On reaching TIMEOUT_CYCLES -> DONE with timeout=1, pass=0. The CRC word is not consumed.
  - The counter clears on entry to WAIT.
- Not defined: no counter; timeout tied 0; WAIT waits indefinitely.

## Test plan
- Frame of 3 words, frame_len=3, data 0x00000001/0x00000002/0x00000003, single-cycle generator model, CRC word = model result -> done at cycle 9, pass=1, crc_calc==crc_rx, exactly one gen_reset and three gen_start pulses.
- Same frame, CRC word XOR 0x00000001 -> done at cycle 9, pass=0, crc_rx = model result XOR 1.
- frame_len=0 -> done at cycle 1, len_err=1, pass=0, no gen_reset/gen_start, s_ready never high.
- Generator holds gen_ready=0 for 5 cycles after each start, s_valid toggling -> s_ready and gen_start low throughout stall, words delivered in order, pass=1.
- Abort and restart: nRST pulsed after 2nd word of 4-word frame -> all outputs 0, no done. Then a 1-word frame -> gen_reset precedes data, pass=1 at cycle 5.
- With CRC_CHECK_TIMEOUT_EN, TIMEOUT_CYCLES=64, gen_ready stuck 0 after first word -> done 64 cycles into WAIT, timeout=1, pass=0, state IDLE next cycle. Without the macro, busy stays 1 indefinitely.

Source files
------------

// File: rtl/crc_frame_checker.sv
// crc_frame_checker: feeds a frame of words through a CRC generator and checks the trailing CRC word.
// Define CRC_CHECK_TIMEOUT_EN to bound each generator wait to TIMEOUT_CYCLES cycles.
module crc_frame_checker #(
  parameter int WORD_SIZE = 32,
  parameter int LEN_W = 8,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic [LEN_W-1:0]     frame_len,
  input  logic [WORD_SIZE-1:0] orient,
  input  logic [WORD_SIZE-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [WORD_SIZE-1:0] gen_data_in,
  output logic                 gen_start,
  output logic                 gen_reset,
  output logic [WORD_SIZE-1:0] gen_orient,
  input  logic [WORD_SIZE-1:0] gen_data_out,
  input  logic                 gen_ready,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 len_err,
  output logic                 timeout,
  output logic [WORD_SIZE-1:0] crc_calc,
  output logic [WORD_SIZE-1:0] crc_rx
);
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, WAIT, CRCWORD, DONE} state_t;
  state_t state;
  logic [LEN_W-1:0] remaining;
  logic xfer;
  logic to_hit;
  assign xfer = state == FEED && s_valid && gen_ready;
  assign s_ready = (state == FEED && gen_ready) || state == CRCWORD;
  assign gen_start = xfer;
  assign gen_data_in = state == FEED ? s_data : '0;
  assign busy = state != IDLE;
`ifdef CRC_CHECK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  // counts stalled WAIT cycles; held at zero outside WAIT so each wait starts fresh
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) tcnt <= '0;
    else tcnt <= state != WAIT ? '0 : tcnt + TW'(!gen_ready);
  assign to_hit = state == WAIT && !gen_ready && tcnt == TW'(TIMEOUT_CYCLES - 1);
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign to_hit = 1'b0;
`endif
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= IDLE;
      remaining <= '0;
      gen_orient <= '0;
      gen_reset <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      len_err <= 1'b0;
      timeout <= 1'b0;
      crc_calc <= '0;
      crc_rx <= '0;
    end else begin
      gen_reset <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          remaining <= frame_len;
          gen_orient <= orient;
          pass <= 1'b0;
          timeout <= 1'b0;
          crc_calc <= '0;
          crc_rx <= '0;
          len_err <= frame_len == '0;
          done <= frame_len == '0;
          gen_reset <= frame_len != '0;
          state <= frame_len == '0 ? DONE : CLEAR;
        end
        CLEAR: state <= FEED;
        FEED: if (xfer) begin
          if (remaining != '0) remaining <= remaining - 1'b1;
          state <= WAIT;
        end
        WAIT: if (gen_ready) begin
          crc_calc <= gen_data_out;
          state <= remaining == '0 ? CRCWORD : FEED;
        end else if (to_hit) begin
          timeout <= 1'b1;
          done <= 1'b1;
          state <= DONE;
        end
        CRCWORD: if (s_valid) begin
          crc_rx <= s_data;
          pass <= crc_calc == s_data;
          done <= 1'b1;
          state <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_crc_frame_checker.sv
// tb_crc_frame_checker: directed frames against a CRC-32 generator model; done results go through a scoreboard.
module tb_crc_frame_checker;
  logic CLK = 0, nRST = 1, start = 0, s_valid = 0;
  logic [7:0] frame_len = '0;
  logic [31:0] orient = '0, s_data = '0;
  logic s_ready, gen_start, gen_reset, busy, done, pass, len_err, timeout, gen_ready;
  logic [31:0] gen_data_in, gen_orient, crc_calc, crc_rx, gen_data_out;
  typedef struct {logic p, le, to; logic [31:0] calc, rx; int lat;} res_t;
  res_t exp_q[$], obs_q[$];
  logic [31:0] fw[8], fed[$], g_acc = '0, fcrc = '0;
  int cyc = 0, c0 = 0, checks = 0, failures = 0, stall_len = 0, g_stall = 0;
  int acc_cnt = 0, n_rst = 0, n_st = 0, n_rdy = 0, n_viol = 0;
  bit stuck = 0;

  always #5 CLK = ~CLK;
  assign gen_ready = g_stall == 0 && !stuck;
  assign gen_data_out = g_acc;

  crc_frame_checker dut (
    .CLK(CLK), .nRST(nRST), .start(start), .frame_len(frame_len), .orient(orient),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .gen_data_in(gen_data_in),
    .gen_start(gen_start), .gen_reset(gen_reset), .gen_orient(gen_orient),
    .gen_data_out(gen_data_out), .gen_ready(gen_ready), .busy(busy), .done(done),
    .pass(pass), .len_err(len_err), .timeout(timeout), .crc_calc(crc_calc), .crc_rx(crc_rx)
  );

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [31:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 31; i >= 0; i--) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  // generator model plus handshake monitors, all sampled at the rising edge
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (gen_reset) g_acc <= 32'hFFFFFFFF;
    else if (gen_start) g_acc <= crc_step(g_acc, gen_data_in);
    if (gen_start) fed.push_back(gen_data_in);
    g_stall <= gen_start ? stall_len : (g_stall > 0 ? g_stall - 1 : 0);
    if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    if (gen_reset) n_rst <= n_rst + 1;
    if (gen_start) n_st <= n_st + 1;
    if (s_ready) n_rdy <= n_rdy + 1;
    if (!gen_ready && (s_ready || gen_start)) n_viol <= n_viol + 1;
  end

  always @(negedge CLK)
    if (done === 1'b1) obs_q.push_back('{pass, len_err, timeout, crc_calc, crc_rx, cyc - c0});

  task automatic chk(input string tag, input logic [127:0] o, input logic [127:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic sb_check();
    res_t e, o;
    chk("done_count", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("pass", o.p, e.p);
      chk("len_err", o.le, e.le);
      chk("timeout", o.to, e.to);
      chk("crc_calc", o.calc, e.calc);
      chk("crc_rx", o.rx, e.rx);
      if (e.lat >= 0) chk("done_cycle", o.lat, e.lat);
    end
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic run_frame(input int n, input logic [31:0] cx, input int stall, input bit tog,
                           input int abort_at, input int stuck_at, input int budget);
    logic [31:0] acc;
    int b_acc, b_rst, b_st, b_rdy, b_viol, b_fed, k, lat, nst;
    bit fin, hang, quit;
    acc = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) acc = crc_step(acc, fw[i]);
    fcrc = acc ^ cx;
    stall_len = stall;
    hang = 0;
    quit = abort_at >= 0;
    lat = n == 0 ? 1 : (stall == 0 && !tog ? 2 * n + 3 : -1);
    nst = n;
    if (stuck_at >= 0) begin
      nst = stuck_at;
`ifdef CRC_CHECK_TIMEOUT_EN
      lat = 2 * stuck_at + 1 + 64;
      exp_q.push_back('{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, lat});
`else
      hang = 1;
`endif
    end else if (!quit)
      exp_q.push_back('{cx == 0 && n != 0, n == 0, 1'b0, n == 0 ? 32'h0 : acc, n == 0 ? 32'h0 : fcrc, lat});
    b_acc = acc_cnt; b_rst = n_rst; b_st = n_st; b_rdy = n_rdy; b_viol = n_viol; b_fed = fed.size();
    @(negedge CLK);
    start = 1; frame_len = 8'(n); orient = 32'hA5A50000 | 32'(n); c0 = cyc;
    @(negedge CLK);
    start = 0;
    k = 0;
    fin = 0;
    while (!fin) begin
      if (quit && acc_cnt - b_acc == abort_at) begin
        nRST = 0; s_valid = 0;
        #1;
        chk("abort_ctrl", {busy, done, pass, len_err, timeout, s_ready, gen_start, gen_reset}, 0);
        chk("abort_data", {gen_orient, crc_calc, crc_rx, gen_data_in}, 0);
        repeat (2) @(negedge CLK);
        nRST = 1;
        fin = 1;
      end else if (busy === 1'b0) fin = 1;
      else if (k == budget) begin
        if (hang) chk("hang_busy", busy, 1);
        else chk("frame_end", busy, 0);
        quit = 1;
        nRST = 0;
        @(negedge CLK);
        nRST = 1;
        fin = 1;
      end else begin
        if (stuck_at >= 0 && acc_cnt - b_acc == stuck_at) stuck = 1;
        s_data = acc_cnt - b_acc < n ? fw[acc_cnt - b_acc] : fcrc;
        s_valid = (acc_cnt - b_acc <= n) && (!tog || cyc[0]);
        @(negedge CLK);
        k++;
      end
    end
    s_valid = 0;
    stuck = 0;
    if (!quit) begin
      if (lat >= 0) chk("idle_cycle", cyc - c0, lat + 1);
      chk("gen_reset_cnt", n_rst - b_rst, n != 0);
      chk("gen_start_cnt", n_st - b_st, nst);
      for (int i = 0; i < nst && b_fed + i < fed.size(); i++) chk("fed_word", fed[b_fed + i], fw[i]);
      chk("stall_viol", n_viol - b_viol, 0);
      chk("gen_orient", gen_orient, 32'hA5A50000 | 32'(n));
      if (n == 0) chk("s_ready_len0", n_rdy - b_rdy, 0);
    end
    sb_check();
  endtask

  initial begin
    #2 nRST = 0;
    #3;
    chk("reset_ctrl", {busy, done, pass, len_err, timeout, s_ready, gen_start, gen_reset}, 0);
    chk("reset_data", {gen_orient, crc_calc, crc_rx, gen_data_in}, 0);
    repeat (2) @(negedge CLK);
    nRST = 1;
    fw[0] = 32'h1; fw[1] = 32'h2; fw[2] = 32'h3;
    run_frame(3, 32'h0, 0, 0, -1, -1, 300);
    run_frame(3, 32'h1, 0, 0, -1, -1, 300);
    run_frame(0, 32'h0, 0, 0, -1, -1, 300);
    for (int i = 0; i < 4; i++) fw[i] = $urandom;
    run_frame(4, 32'h0, 5, 1, -1, -1, 300);
    run_frame(4, 32'h0, 0, 0, 2, -1, 300);
    fw[0] = 32'hDEADBEEF;
    run_frame(1, 32'h0, 0, 0, -1, -1, 300);
    fw[0] = 32'h12345678; fw[1] = 32'h9ABCDEF0;
`ifdef CRC_CHECK_TIMEOUT_EN
    run_frame(2, 32'h0, 0, 0, -1, 1, 300);
`else
    run_frame(2, 32'h0, 0, 0, -1, 1, 150);
`endif
    run_frame(2, 32'h0, 0, 0, -1, -1, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
